// File: rtl/key_event_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_event_pkg
// Brief    : Shared event kinds, event record and key-index width helper.
// Revision : 1.0 - initial release
// ============================================================================
package key_event_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2
    } evt_kind_t;

    // Wide enough for the largest supported bank (16 keys).
    localparam int KEY_IDX_MAX_W = 4;

    typedef struct packed {
        logic [KEY_IDX_MAX_W-1:0] key;
        evt_kind_t                kind;
    } evt_t;

    function automatic int key_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_ch
// Brief    : One key: 2-FF sync, debounce, hold timer, press/release/long.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_ch
    import key_event_pkg::*;
#(
    parameter int DEB_CYC  = 24000,
    parameter int LONG_CYC = 6000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_press_set,
    output logic o_release_set,
    output logic o_long_set
);
    localparam int c_deb_w  = $clog2(DEB_CYC);
    localparam int c_hold_w = $clog2(LONG_CYC + 1);
    localparam logic [c_deb_w-1:0]  c_deb_last  = c_deb_w'(DEB_CYC - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(LONG_CYC - 1);
    localparam logic [c_hold_w-1:0] c_hold_max  = c_hold_w'(LONG_CYC);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_level;
    logic                r_press;
    logic                r_release;
    logic                r_long;
    logic [c_deb_w-1:0]  r_deb;
    logic [c_hold_w-1:0] r_hold;
    logic                w_mismatch;
    logic                w_flip;

    // Raw key is active-low; r_level is active-high.
    assign w_mismatch    = (~r_sync2) != r_level;
    assign w_flip        = w_mismatch && (r_deb == c_deb_last);
    assign o_press_set   = w_flip && !r_level;
    assign o_release_set = w_flip && r_level;
    // A release on the same edge wins over the long event.
    assign o_long_set    = r_level && !w_flip && (r_hold == c_hold_last);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b0;
            r_deb     <= '0;
            r_hold    <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_sync1   <= i_key;
            r_sync2   <= r_sync1;
            r_press   <= o_press_set;
            r_release <= o_release_set;
            r_long    <= o_long_set;
            if (!w_mismatch || w_flip) begin
                r_deb <= '0;
            end else begin
                r_deb <= r_deb + c_deb_w'(1);
            end
            if (w_flip) begin
                r_level <= ~r_level;
                r_hold  <= '0;
            end else if (r_level && (r_hold != c_hold_max)) begin
                r_hold  <= r_hold + c_hold_w'(1);
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule
`default_nettype wire

// File: rtl/key_event_bank.sv
`default_nettype none
// ============================================================================
// Module   : key_event_bank
// Brief    : N debounced key channels merged into one ordered event FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_bank
    import key_event_pkg::*;
#(
    parameter int N_KEY     = 4,
    parameter int DEB_CYC   = 24000,
    parameter int LONG_CYC  = 6000000,
    parameter int EVT_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [N_KEY-1:0]            i_key,
    output logic [N_KEY-1:0]            o_level,
    output logic [N_KEY-1:0]            o_press,
    output logic [N_KEY-1:0]            o_release,
    output logic [N_KEY-1:0]            o_long,
    output logic                        o_evt_valid,
    output logic [key_idx_w(N_KEY)-1:0] o_evt_key,
    output evt_kind_t                   o_evt_kind,
    input  logic                        i_evt_ready,
    output logic                        o_overflow
);
    localparam int c_key_w = key_idx_w(N_KEY);
    localparam int c_ptr_w = $clog2(EVT_DEPTH);
    localparam logic [c_ptr_w:0] c_full_cnt = (c_ptr_w + 1)'(EVT_DEPTH);

    logic [N_KEY-1:0]                w_press_set;
    logic [N_KEY-1:0]                w_release_set;
    logic [N_KEY-1:0]                w_long_set;
    logic [N_KEY-1:0][2:0]           r_pend;
    logic [N_KEY-1:0][2:0]           w_set;
    logic [N_KEY-1:0][2:0]           w_clr;
    logic                            w_lost;
    logic                            w_sel_any;
    logic [KEY_IDX_MAX_W-1:0]        w_sel_ch;
    evt_kind_t                       w_sel_kind;
    evt_t                            r_mem [EVT_DEPTH];
    logic [c_ptr_w-1:0]              r_wr;
    logic [c_ptr_w-1:0]              r_rd;
    logic [c_ptr_w:0]                r_cnt;
    logic                            r_overflow;
    logic                            w_valid;
    logic                            w_full;
    logic                            w_pop;
    logic                            w_push;

    generate
        for (genvar g = 0; g < N_KEY; g++) begin : g_ch
            key_debounce_ch #(
                .DEB_CYC  (DEB_CYC),
                .LONG_CYC (LONG_CYC)
            ) u_ch (
                .i_clk         (i_clk),
                .i_rst_n       (i_rst_n),
                .i_key         (i_key[g]),
                .o_level       (o_level[g]),
                .o_press       (o_press[g]),
                .o_release     (o_release[g]),
                .o_long        (o_long[g]),
                .o_press_set   (w_press_set[g]),
                .o_release_set (w_release_set[g]),
                .o_long_set    (w_long_set[g])
            );
        end
    endgenerate

    // Lowest pending channel wins; within it press > long > release.
    always_comb begin
        w_sel_any  = 1'b0;
        w_sel_ch   = '0;
        w_sel_kind = EVT_PRESS;
        for (int i = N_KEY - 1; i >= 0; i--) begin
            if (|r_pend[i]) begin
                w_sel_any = 1'b1;
                w_sel_ch  = KEY_IDX_MAX_W'(i);
                if (r_pend[i][0]) begin
                    w_sel_kind = EVT_PRESS;
                end else if (r_pend[i][2]) begin
                    w_sel_kind = EVT_LONG;
                end else begin
                    w_sel_kind = EVT_RELEASE;
                end
            end
        end
    end

    assign w_valid = (r_cnt != '0);
    assign w_full  = (r_cnt == c_full_cnt);
    assign w_pop   = w_valid && i_evt_ready;
    assign w_push  = w_sel_any && (!w_full || w_pop);

    // Pending bit index equals the evt_kind_t encoding.
    always_comb begin
        w_lost = 1'b0;
        for (int i = 0; i < N_KEY; i++) begin
            w_set[i] = {w_long_set[i], w_release_set[i], w_press_set[i]};
            w_clr[i] = 3'b000;
            if (w_push && (w_sel_ch == KEY_IDX_MAX_W'(i))) begin
                w_clr[i] = 3'b001 << w_sel_kind;
            end
            if (|(w_set[i] & r_pend[i] & ~w_clr[i])) begin
                w_lost = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pend     <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
            if (w_lost) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_wr <= r_wr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (c_ptr_w + 1)'(1);
                2'b01:   r_cnt <= r_cnt - (c_ptr_w + 1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= '{key: w_sel_ch, kind: w_sel_kind};
        end
    end

    assign o_evt_valid = w_valid;
    assign o_evt_key   = w_valid ? c_key_w'(r_mem[r_rd].key) : '0;
    assign o_evt_kind  = w_valid ? r_mem[r_rd].kind : EVT_PRESS;
    assign o_overflow  = r_overflow;

endmodule
`default_nettype wire
